// File: rtl/bp_vc_pkg.sv
// Shared definitions for the victim cache: the entry struct, shift selects, and count width.
`ifndef BP_VC_PKG_MACROS
`define BP_VC_PKG_MACROS
`define DECLARE_BP_VC_ENTRY_S(data_width_mp, tag_width_mp, stat_width_mp) \
  typedef struct packed { \
    logic                     valid; \
    logic [tag_width_mp-1:0]  tag; \
    logic [stat_width_mp-1:0] stat; \
    logic [data_width_mp-1:0] data; \
  } bp_vc_entry_s
`define BP_VC_ENTRY_WIDTH(data_width_mp, tag_width_mp, stat_width_mp) \
  (1 + (tag_width_mp) + (stat_width_mp) + (data_width_mp))
`endif

package bp_vc_pkg;

  typedef enum logic [1:0] {
    e_vc_hold = 2'd0,
    e_vc_shr  = 2'd1,
    e_vc_shl  = 2'd2,
    e_vc_ext  = 2'd3
  } bp_vc_sel_e;

  function automatic int bp_vc_count_width(input int entries);
    return $clog2(entries + 1);
  endfunction

endpackage

// File: rtl/bp_vc_array_chk.sv
// Simulation checks for the victim cache: an inserted tag must not already be resident.
module bp_vc_array_chk (
  input logic clk_i,
  input logic reset,
  input logic ins,
  input logic dup
);

  a_no_dup_insert: assert property (@(posedge clk_i) disable iff (reset) !(ins && dup))
    else $error("bp_vc_array: inserted tag already resident");

endmodule

// File: rtl/bp_vc_entry.sv
// One victim-cache slot: holds, shifts from either neighbour, or loads a new block.
module bp_vc_entry
  import bp_vc_pkg::*;
#(
  parameter int width_p = 8
) (
  input  logic               clk_i,
  input  logic               reset,
  input  logic [1:0]         sel,
  input  logic               clr,
  input  logic [width_p-1:0] from_left,
  input  logic [width_p-1:0] from_right,
  input  logic [width_p-1:0] from_ext,
  output logic [width_p-1:0] entry
);

  logic [width_p-1:0] entry_r;

  // slot register with synchronous clear (reset or top slot vacated by a take)
  always_ff @(posedge clk_i) begin
    if (reset || clr) begin
      entry_r <= '0;
    end else begin
      case (bp_vc_sel_e'(sel))
        e_vc_shr: entry_r <= from_left;
        e_vc_shl: entry_r <= from_right;
        e_vc_ext: entry_r <= from_ext;
        default:  entry_r <= entry_r;
      endcase
    end
  end

  assign entry = entry_r;

endmodule

// File: rtl/bp_vc_array.sv
// Victim cache kept as an MRU-first shift array; lookups with optional take, LRU evict on overflow.
module bp_vc_array
  import bp_vc_pkg::*;
#(
  parameter int block_width_p = 512,
  parameter int tag_width_p   = 32,
  parameter int stat_width_p  = 2,
  parameter int entries_p     = 8
) (
  input  logic                                     clk_i,
  input  logic                                     reset,
  input  logic                                     ins_v_i,
  output logic                                     ins_ready_o,
  input  logic [block_width_p-1:0]                 ins_data_i,
  input  logic [tag_width_p-1:0]                   ins_tag_i,
  input  logic [stat_width_p-1:0]                  ins_stat_i,
  input  logic                                     lkp_v_i,
  input  logic [tag_width_p-1:0]                   lkp_tag_i,
  input  logic                                     lkp_take_i,
  output logic                                     lkp_v_o,
  output logic                                     lkp_hit_o,
  output logic [block_width_p-1:0]                 lkp_data_o,
  output logic [stat_width_p-1:0]                  lkp_stat_o,
  output logic                                     ev_v_o,
  input  logic                                     ev_ready_i,
  output logic [block_width_p-1:0]                 ev_data_o,
  output logic [tag_width_p-1:0]                   ev_tag_o,
  output logic [stat_width_p-1:0]                  ev_stat_o,
  output logic [bp_vc_count_width(entries_p)-1:0]  count_o
);

  localparam int cw_lp = bp_vc_count_width(entries_p);
  localparam int iw_lp = $clog2(entries_p);
  localparam int ew_lp = `BP_VC_ENTRY_WIDTH(block_width_p, tag_width_p, stat_width_p);

  `DECLARE_BP_VC_ENTRY_S(block_width_p, tag_width_p, stat_width_p);

  bp_vc_entry_s [entries_p-1:0]            entry;
  logic [entries_p-1:0][ew_lp-1:0]         left_src;
  logic [entries_p-1:0][ew_lp-1:0]         right_src;
  logic [entries_p-1:0][1:0]               sel;
  logic [entries_p-1:0]                    clr;
  bp_vc_entry_s                            ins_entry;
  logic [cw_lp-1:0]                        count;
  logic [iw_lp-1:0]                        hit_idx;
  logic                                    hit, dup, full, take, ins;

  logic                                    lkp_v_r, lkp_hit_r;
  logic [block_width_p-1:0]                lkp_data_r;
  logic [stat_width_p-1:0]                 lkp_stat_r;

  // occupancy, lowest-index lookup hit, and duplicate-insert detection
  always_comb begin
    count   = '0;
    hit     = 1'b0;
    hit_idx = '0;
    dup     = 1'b0;
    for (int i = entries_p - 1; i >= 0; i--) begin
      count = count + cw_lp'(entry[i].valid);
      if (entry[i].valid && (entry[i].tag == lkp_tag_i)) begin
        hit     = 1'b1;
        hit_idx = iw_lp'(i);
      end
      if (entry[i].valid && (entry[i].tag == ins_tag_i)) begin
        dup = 1'b1;
      end
    end
  end

  assign full        = entry[entries_p-1].valid;
  assign take        = !reset && lkp_v_i && lkp_take_i && hit;
  assign ins_ready_o = reset || !full || ev_ready_i || take;
  assign ins         = !reset && ins_v_i && ins_ready_o;
  // a take frees a slot, so a simultaneous insert never needs the LRU pushed out
  assign ev_v_o      = !reset && full && ins_v_i && !take;
  assign ev_data_o   = ev_v_o ? entry[entries_p-1].data : '0;
  assign ev_tag_o    = ev_v_o ? entry[entries_p-1].tag  : '0;
  assign ev_stat_o   = ev_v_o ? entry[entries_p-1].stat : '0;
  assign count_o     = reset ? '0 : count;

  assign ins_entry.valid = 1'b1;
  assign ins_entry.tag   = ins_tag_i;
  assign ins_entry.stat  = ins_stat_i;
  assign ins_entry.data  = ins_data_i;

  assign left_src  = {entry[entries_p-2:0], {ew_lp{1'b0}}};
  assign right_src = {{ew_lp{1'b0}}, entry[entries_p-1:1]};

  // per-slot shift controls from insert/take qualifiers, hit index and occupancy
  always_comb begin
    for (int i = 0; i < entries_p; i++) begin
      sel[i] = e_vc_hold;
      clr[i] = 1'b0;
      if (ins) begin
        if (i == 0) begin
          sel[i] = e_vc_ext;
        end else if (take ? (i <= int'(hit_idx)) : (i <= int'(count))) begin
          sel[i] = e_vc_shr;
        end else begin
          sel[i] = e_vc_hold;
        end
      end else if (take) begin
        if (i == int'(count) - 1) begin
          clr[i] = 1'b1;
        end else if ((i >= int'(hit_idx)) && (i < int'(count) - 1)) begin
          sel[i] = e_vc_shl;
        end else begin
          sel[i] = e_vc_hold;
        end
      end else begin
        sel[i] = e_vc_hold;
      end
    end
  end

  for (genvar g = 0; g < entries_p; g++) begin : g_entry
    bp_vc_entry #(.width_p(ew_lp)) u_entry (
      .clk_i      (clk_i),
      .reset      (reset),
      .sel        (sel[g]),
      .clr        (clr[g]),
      .from_left  (left_src[g]),
      .from_right (right_src[g]),
      .from_ext   (ins_entry),
      .entry      (entry[g])
    );
  end

  // registered lookup response, sampled against pre-update contents
  always_ff @(posedge clk_i) begin
    if (reset) begin
      lkp_v_r    <= 1'b0;
      lkp_hit_r  <= 1'b0;
      lkp_data_r <= '0;
      lkp_stat_r <= '0;
    end else begin
      lkp_v_r    <= lkp_v_i;
      lkp_hit_r  <= lkp_v_i && hit;
      lkp_data_r <= (lkp_v_i && hit) ? entry[hit_idx].data : '0;
      lkp_stat_r <= (lkp_v_i && hit) ? entry[hit_idx].stat : '0;
    end
  end

  assign lkp_v_o    = lkp_v_r;
  assign lkp_hit_o  = lkp_hit_r;
  assign lkp_data_o = lkp_data_r;
  assign lkp_stat_o = lkp_stat_r;

  bp_vc_array_chk u_chk (
    .clk_i (clk_i),
    .reset (reset),
    .ins   (ins),
    .dup   (dup)
  );

endmodule

// File: tb/tb_bp_vc_array.sv
// Randomised and directed bench for bp_vc_array against a queue-based MRU-first model.
module tb_bp_vc_array;

  localparam int DW = 512;
  localparam int TW = 32;
  localparam int SW = 2;
  localparam int N  = 8;
  localparam int CW = $clog2(N + 1);

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          ins_v = 1'b0, ins_ready;
  logic [DW-1:0] ins_data = '0;
  logic [TW-1:0] ins_tag = '0;
  logic [SW-1:0] ins_stat = '0;
  logic          lkp_v = 1'b0, lkp_take = 1'b0;
  logic [TW-1:0] lkp_tag = '0;
  logic          rsp_v, rsp_hit;
  logic [DW-1:0] rsp_data;
  logic [SW-1:0] rsp_stat;
  logic          ev_v, ev_ready = 1'b0;
  logic [DW-1:0] ev_data;
  logic [TW-1:0] ev_tag;
  logic [SW-1:0] ev_stat;
  logic [CW-1:0] count;

  typedef struct {
    logic [TW-1:0] tag;
    logic [SW-1:0] stat;
    logic [DW-1:0] data;
  } ent_t;

  ent_t model[$];
  int   total = 0;
  int   bad = 0;

  always #5 clk = ~clk;

  bp_vc_array #(
    .block_width_p(DW), .tag_width_p(TW), .stat_width_p(SW), .entries_p(N)
  ) dut (
    .clk_i(clk), .reset(reset),
    .ins_v_i(ins_v), .ins_ready_o(ins_ready), .ins_data_i(ins_data),
    .ins_tag_i(ins_tag), .ins_stat_i(ins_stat),
    .lkp_v_i(lkp_v), .lkp_tag_i(lkp_tag), .lkp_take_i(lkp_take),
    .lkp_v_o(rsp_v), .lkp_hit_o(rsp_hit), .lkp_data_o(rsp_data), .lkp_stat_o(rsp_stat),
    .ev_v_o(ev_v), .ev_ready_i(ev_ready), .ev_data_o(ev_data),
    .ev_tag_o(ev_tag), .ev_stat_o(ev_stat), .count_o(count)
  );

  task automatic check_eq(input string name, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic int find_tag(input logic [TW-1:0] t);
    for (int i = 0; i < model.size(); i++) begin
      if (model[i].tag == t) return i;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] r;
    for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // one clock of stimulus: check combinational outputs, then the registered response
  task automatic step(input logic iv, input logic [TW-1:0] itag, input logic lv,
                      input logic [TW-1:0] ltag, input logic tk, input logic er);
    int   k;
    logic full, tak, rdy, evv, acc;
    ent_t ne, lk;
    @(negedge clk);
    ne.tag  = itag;
    ne.stat = SW'($urandom);
    ne.data = rand_data();
    ins_v = iv; ins_tag = itag; ins_stat = ne.stat; ins_data = ne.data;
    lkp_v = lv; lkp_tag = ltag; lkp_take = tk; ev_ready = er;
    #1;
    k    = lv ? find_tag(ltag) : -1;
    full = (model.size() == N);
    tak  = lv && tk && (k >= 0);
    rdy  = !full || er || tak;
    evv  = full && iv && !tak;
    check_eq("ins_ready", ins_ready, rdy);
    check_eq("ev_v", ev_v, evv);
    if (evv) begin
      check_eq("ev_tag", ev_tag, model[N-1].tag);
      check_eq("ev_data", ev_data, model[N-1].data);
      check_eq("ev_stat", ev_stat, model[N-1].stat);
    end
    check_eq("count", count, model.size());
    lk.tag = '0; lk.stat = '0; lk.data = '0;
    if (k >= 0) lk = model[k];
    acc = iv && rdy;
    if (tak) model.delete(k);
    else if (acc && full) void'(model.pop_back());
    if (acc) model.push_front(ne);
    @(posedge clk);
    #1;
    check_eq("lkp_v", rsp_v, lv);
    check_eq("lkp_hit", rsp_hit, k >= 0);
    check_eq("lkp_data", rsp_data, lk.data);
    check_eq("lkp_stat", rsp_stat, lk.stat);
    check_eq("count_post", count, model.size());
  endtask

  task automatic do_reset(input logic lv, input logic [TW-1:0] ltag);
    @(negedge clk);
    reset = 1'b1; ins_v = 1'b0; lkp_v = lv; lkp_tag = ltag; lkp_take = 1'b0; ev_ready = 1'b0;
    @(posedge clk);
    #1;
    check_eq("rst_ins_ready", ins_ready, 1'b1);
    check_eq("rst_count", count, 0);
    check_eq("rst_lkp_v", rsp_v, 1'b0);
    check_eq("rst_ev_v", ev_v, 1'b0);
    model.delete();
    @(negedge clk);
    reset = 1'b0; lkp_v = 1'b0;
  endtask

  initial begin : main
    logic          iv, lv, tk, er;
    logic [TW-1:0] itag, ltag;

    do_reset(1'b0, '0);
    step(1'b1, 32'h10, 1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 32'h20, 1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 32'h30, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 32'h20, 1'b1, 1'b1);
    step(1'b0, '0, 1'b1, 32'h55, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 32'h10, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 32'h20, 1'b1, 1'b1);

    // full array: eviction, then back-pressure, then release
    do_reset(1'b0, '0);
    for (int t = 1; t <= 8; t++) step(1'b1, TW'(t), 1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 32'd9, 1'b0, '0, 1'b0, 1'b1);
    for (int c = 0; c < 3; c++) step(1'b1, 32'd10, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 32'd10, 1'b0, '0, 1'b0, 1'b1);

    // full array: insert with a same-cycle take, then drain via evictions to expose order
    do_reset(1'b0, '0);
    for (int t = 1; t <= 8; t++) step(1'b1, TW'(t), 1'b0, '0, 1'b0, 1'b1);
    step(1'b1, 32'd9, 1'b1, 32'd5, 1'b1, 1'b0);
    for (int t = 10; t <= 17; t++) step(1'b1, TW'(t), 1'b0, '0, 1'b0, 1'b1);

    // take down to empty, then take on empty
    for (int t = 17; t >= 10; t--) step(1'b0, '0, 1'b1, TW'(t), 1'b1, 1'b0);
    step(1'b0, '0, 1'b1, 32'd12, 1'b1, 1'b0);

    for (int n = 0; n < 1500; n++) begin
      itag = TW'($urandom_range(1, 24));
      iv   = ($urandom_range(0, 99) < 60) && (find_tag(itag) < 0);
      lv   = $urandom_range(0, 1) == 1;
      ltag = TW'($urandom_range(1, 24));
      tk   = $urandom_range(0, 1) == 1;
      er   = $urandom_range(0, 99) < 70;
      step(iv, itag, lv, ltag, tk, er);
    end

    // lookup response registered, then reset arrives with another lookup pending
    step(1'b1, 32'h77, 1'b0, '0, 1'b0, 1'b1);
    step(1'b0, '0, 1'b1, 32'h77, 1'b0, 1'b1);
    do_reset(1'b1, 32'h77);
    step(1'b0, '0, 1'b1, 32'h77, 1'b0, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
